// File: rtl/fetch_sequencer_if.sv
// Fetch/hazard control bundle between the pipeline datapath and fetch_sequencer.
// The master drives the hazard and redirect requests; the slave (the sequencer) drives the controls.
interface fetch_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             fetch_halt;
  logic             load_use;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             pc_write_en;
  logic             npc_control;
  logic [31:0]      branch_pc;
  logic             ifid_write_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             halt_out;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output fetch_halt, load_use, redirect_valid, redirect_pc,
    input  pc_write_en, npc_control, branch_pc, ifid_write_en, ifid_flush,
           idex_flush, halt_out, state, stall_count, flush_count
  );

  modport slave (
    input  fetch_halt, load_use, redirect_valid, redirect_pc,
    output pc_write_en, npc_control, branch_pc, ifid_write_en, ifid_flush,
           idex_flush, halt_out, state, stall_count, flush_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch/hazard controller: arbitrates redirects, load-use stalls and halt requests,
// drains the pipeline before halting, and keeps saturating stall/flush counters.
module fetch_sequencer #(
  parameter int DRAIN_CYCLES = 4,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input logic              clk,
  input logic              rst,
  fetch_sequencer_if.slave bus
);
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [3:0]       DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);
  localparam logic [3:0]       FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             halt_q, halt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic pc_we, npc_sel, ifid_we, ifid_fl, idex_fl;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
      halt_q  <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      halt_q  <= halt_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    halt_d  = halt_q;
    stall_d = stall_q;
    flush_d = flush_q;
    pc_we   = 1'b0;
    npc_sel = 1'b0;
    ifid_we = 1'b0;
    ifid_fl = 1'b0;
    idex_fl = 1'b0;

    // A redirect wins everywhere except HALTED; in DRAIN it cancels a wrong-path halt.
    if (state_q != HALTED && bus.redirect_valid) begin
      pc_we   = 1'b1;
      npc_sel = 1'b1;
      ifid_we = 1'b1;
      ifid_fl = 1'b1;
      idex_fl = 1'b1;
      state_d = FLUSH;
      cnt_d   = FLUSH_LOAD;
      if (flush_q != CNT_MAX) flush_d = flush_q + CNT_W'(1);
    end else begin
      case (state_q)
        RUN: begin
          if (bus.load_use) begin
            idex_fl = 1'b1;
            if (stall_q != CNT_MAX) stall_d = stall_q + CNT_W'(1);
          end else if (bus.fetch_halt) begin
            // PC stays on the halting word while a bubble replaces it in IF/ID.
            ifid_we = 1'b1;
            ifid_fl = 1'b1;
            state_d = DRAIN;
            cnt_d   = DRAIN_LOAD;
          end else begin
            pc_we   = 1'b1;
            ifid_we = 1'b1;
          end
        end
        FLUSH: begin
          pc_we   = 1'b1;
          ifid_we = 1'b1;
          ifid_fl = 1'b1;
          if (cnt_q == 4'd0) state_d = RUN;
          else               cnt_d   = cnt_q - 4'd1;
        end
        DRAIN: begin
          ifid_we = 1'b1;
          ifid_fl = 1'b1;
          if (cnt_q == 4'd0) begin
            state_d = HALTED;
            halt_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        HALTED: begin
          ifid_fl = 1'b1;
          idex_fl = 1'b1;
          halt_d  = 1'b1;
        end
        default: state_d = RUN;
      endcase
    end

    // Hold the pipeline quiet with bubbles while reset is asserted.
    if (!rst) begin
      pc_we   = 1'b0;
      npc_sel = 1'b0;
      ifid_we = 1'b0;
      ifid_fl = 1'b1;
      idex_fl = 1'b1;
    end
  end

  assign bus.pc_write_en   = pc_we;
  assign bus.npc_control   = npc_sel;
  assign bus.branch_pc     = bus.redirect_pc;
  assign bus.ifid_write_en = ifid_we;
  assign bus.ifid_flush    = ifid_fl;
  assign bus.idex_flush    = idex_fl;
  assign bus.halt_out      = halt_q;
  assign bus.state         = state_q;
  assign bus.stall_count   = stall_q;
  assign bus.flush_count   = flush_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized traffic
// compared against a phase/countdown reference model.
module tb_fetch_sequencer;
  localparam int CNT_W        = 4;
  localparam int DRAIN_CYCLES = 4;
  localparam int FLUSH_CYCLES = 1;
  localparam int CNT_SAT      = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  fetch_sequencer_if #(.CNT_W(CNT_W)) bus ();

  fetch_sequencer #(
    .DRAIN_CYCLES(DRAIN_CYCLES),
    .FLUSH_CYCLES(FLUSH_CYCLES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: which phase the pipeline is in and how many cycles of it remain.
  bit m_in_flush, m_in_drain, m_halted;
  int m_left, m_stall, m_flush;

  function automatic int sat_inc(input int v);
    return (v >= CNT_SAT) ? CNT_SAT : v + 1;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_in_flush <= 1'b0; m_in_drain <= 1'b0; m_halted <= 1'b0;
      m_left <= 0; m_stall <= 0; m_flush <= 0;
    end else if (!m_halted) begin
      if (bus.redirect_valid) begin
        m_in_flush <= 1'b1; m_in_drain <= 1'b0;
        m_left <= FLUSH_CYCLES; m_flush <= sat_inc(m_flush);
      end else if (m_in_flush) begin
        m_left <= m_left - 1;
        if (m_left == 1) m_in_flush <= 1'b0;
      end else if (m_in_drain) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin m_in_drain <= 1'b0; m_halted <= 1'b1; end
      end else if (bus.load_use) begin
        m_stall <= sat_inc(m_stall);
      end else if (bus.fetch_halt) begin
        m_in_drain <= 1'b1; m_left <= DRAIN_CYCLES;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.fetch_halt = 1'b0; bus.load_use = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b0; clear_inputs(); tick(); tick(); rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; clear_inputs();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hDEAD_BEE0;
    tick(); tick();
    @(negedge clk);
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", bus.state); end
    checks++; if (bus.halt_out !== 1'b0) begin errors++; $display("FAIL reset_halt got=%b exp=0", bus.halt_out); end
    checks++; if (bus.stall_count !== 4'd0) begin errors++; $display("FAIL reset_stall got=%0d exp=0", bus.stall_count); end
    checks++; if (bus.flush_count !== 4'd0) begin errors++; $display("FAIL reset_flushcnt got=%0d exp=0", bus.flush_count); end
    checks++; if (bus.ifid_flush !== 1'b1) begin errors++; $display("FAIL reset_ifid_flush got=%b exp=1", bus.ifid_flush); end
    checks++; if (bus.idex_flush !== 1'b1) begin errors++; $display("FAIL reset_idex_flush got=%b exp=1", bus.idex_flush); end
    checks++; if (bus.pc_write_en !== 1'b0) begin errors++; $display("FAIL reset_pc_we got=%b exp=0", bus.pc_write_en); end
    checks++; if (bus.npc_control !== 1'b0) begin errors++; $display("FAIL reset_npc got=%b exp=0", bus.npc_control); end
    checks++; if (bus.ifid_write_en !== 1'b0) begin errors++; $display("FAIL reset_ifid_we got=%b exp=0", bus.ifid_write_en); end
    checks++; if (bus.branch_pc !== 32'hDEAD_BEE0) begin errors++; $display("FAIL reset_branch_pc got=%h exp=deadbee0", bus.branch_pc); end
    $display("test_reset: done");
    rst = 1'b1; clear_inputs(); tick();
  endtask

  task automatic test_load_use();
    do_reset();
    bus.load_use = 1'b1; bus.fetch_halt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.pc_write_en !== 1'b0) begin errors++; $display("FAIL lu_pc_we[%0d] got=%b exp=0", i, bus.pc_write_en); end
      checks++; if (bus.ifid_write_en !== 1'b0) begin errors++; $display("FAIL lu_ifid_we[%0d] got=%b exp=0", i, bus.ifid_write_en); end
      checks++; if (bus.idex_flush !== 1'b1) begin errors++; $display("FAIL lu_idex_flush[%0d] got=%b exp=1", i, bus.idex_flush); end
      tick();
    end
    clear_inputs();
    @(negedge clk);
    checks++; if (bus.stall_count !== 4'd3) begin errors++; $display("FAIL lu_stall_count got=%0d exp=3", bus.stall_count); end
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL lu_state got=%0d exp=0", bus.state); end
    checks++; if (bus.pc_write_en !== 1'b1) begin errors++; $display("FAIL lu_run_pc_we got=%b exp=1", bus.pc_write_en); end
    $display("test_load_use: stall_count=%0d", bus.stall_count);
  endtask

  task automatic test_redirect();
    do_reset();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0040;
    @(negedge clk);
    checks++; if (bus.npc_control !== 1'b1) begin errors++; $display("FAIL rd_npc got=%b exp=1", bus.npc_control); end
    checks++; if (bus.branch_pc !== 32'h40) begin errors++; $display("FAIL rd_branch_pc got=%h exp=40", bus.branch_pc); end
    checks++; if (bus.ifid_flush !== 1'b1 || bus.idex_flush !== 1'b1) begin errors++; $display("FAIL rd_flushes got=%b%b exp=11", bus.ifid_flush, bus.idex_flush); end
    checks++; if (bus.pc_write_en !== 1'b1) begin errors++; $display("FAIL rd_pc_we got=%b exp=1", bus.pc_write_en); end
    tick(); clear_inputs();
    @(negedge clk);
    checks++; if (bus.state !== 2'd1) begin errors++; $display("FAIL rd_state_flush got=%0d exp=1", bus.state); end
    checks++; if (bus.npc_control !== 1'b0) begin errors++; $display("FAIL rd_npc_idle got=%b exp=0", bus.npc_control); end
    tick();
    @(negedge clk);
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL rd_state_run got=%0d exp=0", bus.state); end
    checks++; if (bus.flush_count !== 4'd1) begin errors++; $display("FAIL rd_flush_count got=%0d exp=1", bus.flush_count); end
    $display("test_redirect: flush_count=%0d", bus.flush_count);
  endtask

  task automatic test_halt();
    do_reset();
    bus.fetch_halt = 1'b1;
    @(negedge clk);
    checks++; if (bus.pc_write_en !== 1'b0) begin errors++; $display("FAIL ht_detect_pc_we got=%b exp=0", bus.pc_write_en); end
    checks++; if (bus.ifid_flush !== 1'b1) begin errors++; $display("FAIL ht_detect_ifid_flush got=%b exp=1", bus.ifid_flush); end
    tick(); clear_inputs();
    for (int i = 0; i < DRAIN_CYCLES; i++) begin
      @(negedge clk);
      checks++; if (bus.state !== 2'd2) begin errors++; $display("FAIL ht_drain_state[%0d] got=%0d exp=2", i, bus.state); end
      checks++; if (bus.pc_write_en !== 1'b0) begin errors++; $display("FAIL ht_drain_pc_we[%0d] got=%b exp=0", i, bus.pc_write_en); end
      checks++; if (bus.idex_flush !== 1'b0) begin errors++; $display("FAIL ht_drain_idex[%0d] got=%b exp=0", i, bus.idex_flush); end
      checks++; if (bus.halt_out !== 1'b0) begin errors++; $display("FAIL ht_drain_halt[%0d] got=%b exp=0", i, bus.halt_out); end
      tick();
    end
    @(negedge clk);
    checks++; if (bus.state !== 2'd3) begin errors++; $display("FAIL ht_state got=%0d exp=3", bus.state); end
    checks++; if (bus.halt_out !== 1'b1) begin errors++; $display("FAIL ht_halt_out got=%b exp=1", bus.halt_out); end
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h80;
    @(negedge clk);
    checks++; if (bus.npc_control !== 1'b0) begin errors++; $display("FAIL ht_npc_ignored got=%b exp=0", bus.npc_control); end
    tick(); tick();
    @(negedge clk);
    checks++; if (bus.halt_out !== 1'b1 || bus.state !== 2'd3) begin errors++; $display("FAIL ht_sticky got=%b/%0d exp=1/3", bus.halt_out, bus.state); end
    checks++; if (bus.flush_count !== 4'd0) begin errors++; $display("FAIL ht_flush_count got=%0d exp=0", bus.flush_count); end
    $display("test_halt: halt_out=%b", bus.halt_out);
    clear_inputs();
  endtask

  task automatic test_halt_abort();
    do_reset();
    bus.fetch_halt = 1'b1;
    tick(); clear_inputs();
    @(negedge clk);
    checks++; if (bus.state !== 2'd2) begin errors++; $display("FAIL ab_drain1 got=%0d exp=2", bus.state); end
    tick();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h100; bus.load_use = 1'b1;
    @(negedge clk);
    checks++; if (bus.npc_control !== 1'b1) begin errors++; $display("FAIL ab_npc got=%b exp=1", bus.npc_control); end
    checks++; if (bus.branch_pc !== 32'h100) begin errors++; $display("FAIL ab_branch_pc got=%h exp=100", bus.branch_pc); end
    tick(); clear_inputs();
    @(negedge clk);
    checks++; if (bus.state !== 2'd1) begin errors++; $display("FAIL ab_flush got=%0d exp=1", bus.state); end
    tick();
    @(negedge clk);
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL ab_run got=%0d exp=0", bus.state); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if (bus.halt_out !== 1'b0) begin errors++; $display("FAIL ab_no_halt[%0d] got=%b exp=0", i, bus.halt_out); end
      tick();
    end
    $display("test_halt_abort: state=%0d halt_out=%b", bus.state, bus.halt_out);
  endtask

  task automatic test_saturation();
    do_reset();
    bus.load_use = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    clear_inputs();
    @(negedge clk);
    checks++; if (bus.stall_count !== 4'd15) begin errors++; $display("FAIL sat_stall got=%0d exp=15", bus.stall_count); end
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h200;
    tick();
    @(negedge clk);
    checks++; if (bus.state !== 2'd1 || bus.npc_control !== 1'b1) begin errors++; $display("FAIL sat_flush_redirect got=%0d/%b exp=1/1", bus.state, bus.npc_control); end
    tick(); clear_inputs();
    @(negedge clk);
    checks++; if (bus.state !== 2'd1) begin errors++; $display("FAIL sat_reload got=%0d exp=1", bus.state); end
    checks++; if (bus.flush_count !== 4'd2) begin errors++; $display("FAIL sat_flush_count2 got=%0d exp=2", bus.flush_count); end
    tick();
    @(negedge clk);
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL sat_back_run got=%0d exp=0", bus.state); end
    bus.redirect_valid = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    clear_inputs();
    @(negedge clk);
    checks++; if (bus.flush_count !== 4'd15) begin errors++; $display("FAIL sat_flush_count got=%0d exp=15", bus.flush_count); end
    $display("test_saturation: stall=%0d flush=%0d", bus.stall_count, bus.flush_count);
  endtask

  task automatic test_random();
    logic e_pwe, e_npc, e_ifwe, e_iff, e_idf, care_ifwe;
    int   e_state;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) != 0);
      bus.redirect_valid = ($urandom_range(0, 7) == 0);
      bus.load_use       = ($urandom_range(0, 3) == 0);
      bus.fetch_halt     = ($urandom_range(0, 9) == 0);
      bus.redirect_pc    = $urandom;
      @(negedge clk);
      care_ifwe = 1'b1;
      if (!rst)                    {e_pwe, e_npc, e_ifwe, e_iff, e_idf} = 5'b00011;
      else if (m_halted)           {e_pwe, e_npc, e_ifwe, e_iff, e_idf} = 5'b00011;
      else if (bus.redirect_valid) begin {e_pwe, e_npc, e_ifwe, e_iff, e_idf} = 5'b11111; care_ifwe = 1'b0; end
      else if (m_in_flush)         {e_pwe, e_npc, e_ifwe, e_iff, e_idf} = 5'b10110;
      else if (m_in_drain)         begin {e_pwe, e_npc, e_ifwe, e_iff, e_idf} = 5'b00110; care_ifwe = 1'b0; end
      else if (bus.load_use)       {e_pwe, e_npc, e_ifwe, e_iff, e_idf} = 5'b00001;
      else if (bus.fetch_halt)     begin {e_pwe, e_npc, e_ifwe, e_iff, e_idf} = 5'b00110; care_ifwe = 1'b0; end
      else                         {e_pwe, e_npc, e_ifwe, e_iff, e_idf} = 5'b10100;
      e_state = m_halted ? 3 : m_in_drain ? 2 : m_in_flush ? 1 : 0;
      checks++; if (int'(bus.state) !== e_state) begin errors++; $display("FAIL rnd_state[%0d] got=%0d exp=%0d", n, bus.state, e_state); end
      checks++; if (bus.halt_out !== m_halted) begin errors++; $display("FAIL rnd_halt[%0d] got=%b exp=%b", n, bus.halt_out, m_halted); end
      checks++; if (int'(bus.stall_count) !== m_stall) begin errors++; $display("FAIL rnd_stall[%0d] got=%0d exp=%0d", n, bus.stall_count, m_stall); end
      checks++; if (int'(bus.flush_count) !== m_flush) begin errors++; $display("FAIL rnd_flushcnt[%0d] got=%0d exp=%0d", n, bus.flush_count, m_flush); end
      checks++; if (bus.pc_write_en !== e_pwe) begin errors++; $display("FAIL rnd_pc_we[%0d] got=%b exp=%b", n, bus.pc_write_en, e_pwe); end
      checks++; if (bus.npc_control !== e_npc) begin errors++; $display("FAIL rnd_npc[%0d] got=%b exp=%b", n, bus.npc_control, e_npc); end
      checks++; if (bus.ifid_flush !== e_iff) begin errors++; $display("FAIL rnd_ifid_flush[%0d] got=%b exp=%b", n, bus.ifid_flush, e_iff); end
      checks++; if (bus.idex_flush !== e_idf) begin errors++; $display("FAIL rnd_idex_flush[%0d] got=%b exp=%b", n, bus.idex_flush, e_idf); end
      checks++; if (bus.branch_pc !== bus.redirect_pc) begin errors++; $display("FAIL rnd_branch_pc[%0d] got=%h exp=%h", n, bus.branch_pc, bus.redirect_pc); end
      if (care_ifwe) begin
        checks++; if (bus.ifid_write_en !== e_ifwe) begin errors++; $display("FAIL rnd_ifid_we[%0d] got=%b exp=%b", n, bus.ifid_write_en, e_ifwe); end
      end
      tick();
    end
    rst = 1'b1; clear_inputs();
    $display("test_random: 400 cycles, stall=%0d flush=%0d", m_stall, m_flush);
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_load_use();
    test_redirect();
    test_halt();
    test_halt_abort();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
